seq_normalizer: RTL and testbench

//   Multi-cycle normalizer, the inverse companion of the barrel shifter. The shifter applies a known

---
 rtl/seq_normalizer.sv | 157 +++++++++++++++
 tb/tb_seq_normalizer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: shifts a word toward its MSB (CLZ) or LSB (CTZ) and reports the shift count.
// Optional FAST_SHIFT_EN macro: skip four zero bits per cycle when the nearest nibble is clear.
module seq_normalizer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] sh_cnt,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic             dir_reg, dir_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [CNT_W-1:0] sh_cnt_reg, sh_cnt_next;
  logic             zero_reg, zero_next;

  logic [WIDTH-1:0] shl1, shr1;
  logic             target_bit;
  logic             work_is_zero;

  // Single-step shifted copies of the working word, zero filled.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift1
    if (gi >= 1) begin : g_l
      assign shl1[gi] = work_reg[gi-1];
    end else begin : g_lz
      assign shl1[gi] = 1'b0;
    end
    if (gi < WIDTH - 1) begin : g_r
      assign shr1[gi] = work_reg[gi+1];
    end else begin : g_rz
      assign shr1[gi] = 1'b0;
    end
  end

`ifdef FAST_SHIFT_EN
  logic [WIDTH-1:0] shl4, shr4;
  logic             near_zero;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift4
    if (gi >= 4) begin : g_l
      assign shl4[gi] = work_reg[gi-4];
    end else begin : g_lz
      assign shl4[gi] = 1'b0;
    end
    if (gi < WIDTH - 4) begin : g_r
      assign shr4[gi] = work_reg[gi+4];
    end else begin : g_rz
      assign shr4[gi] = 1'b0;
    end
  end

  // A clear nibble next to the target can never hide the target bit, so a 4-bit hop is safe.
  assign near_zero = dir_reg ? (work_reg[3:0] == 4'd0) : (work_reg[WIDTH-1 -: 4] == 4'd0);
`endif

  assign target_bit   = dir_reg ? work_reg[0] : work_reg[WIDTH-1];
  assign work_is_zero = (work_reg == '0);

  always_comb begin
    state_next    = state_reg;
    work_next     = work_reg;
    dir_next      = dir_reg;
    cnt_next      = cnt_reg;
    out_data_next = out_data_reg;
    sh_cnt_next   = sh_cnt_reg;
    zero_next     = zero_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          work_next  = in_data;
          dir_next   = dir;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (work_is_zero) begin
          out_data_next = '0;
          sh_cnt_next   = '0;
          zero_next     = 1'b1;
          state_next    = DONE;
        end else if (target_bit) begin
          out_data_next = work_reg;
          sh_cnt_next   = cnt_reg;
          zero_next     = 1'b0;
          state_next    = DONE;
        end else begin
`ifdef FAST_SHIFT_EN
          if (near_zero) begin
            work_next = dir_reg ? shr4 : shl4;
            cnt_next  = cnt_reg + CNT_W'(4);
          end else begin
            work_next = dir_reg ? shr1 : shl1;
            cnt_next  = cnt_reg + CNT_W'(1);
          end
`else
          work_next = dir_reg ? shr1 : shl1;
          cnt_next  = cnt_reg + CNT_W'(1);
`endif
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      work_reg     <= '0;
      dir_reg      <= 1'b0;
      cnt_reg      <= '0;
      out_data_reg <= '0;
      sh_cnt_reg   <= '0;
      zero_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      work_reg     <= work_next;
      dir_reg      <= dir_next;
      cnt_reg      <= cnt_next;
      out_data_reg <= out_data_next;
      sh_cnt_reg   <= sh_cnt_next;
      zero_reg     <= zero_next;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign out_data = out_data_reg;
  assign sh_cnt   = sh_cnt_reg;
  assign zero     = zero_reg;

endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: expected results are queued at start and checked on done.
module tb_seq_normalizer;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             busy, done, zero;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] sh_cnt;

  seq_normalizer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .in_data(in_data),
    .busy(busy), .done(done), .out_data(out_data), .sh_cnt(sh_cnt), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             zero;
  } exp_t;

  exp_t sb_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic logic tgt(input logic d, input logic [WIDTH-1:0] w);
    return d ? w[0] : w[WIDTH-1];
  endfunction

  // Reference: normalized word, zero count and cycles from accept edge to done.
  task automatic model(input logic d, input logic [WIDTH-1:0] data, output exp_t e, output int lat);
    logic [WIDTH-1:0] w;
    int n, steps;
    if (data == '0) begin
      e = '{data: '0, cnt: '0, zero: 1'b1};
      lat = 1;
      return;
    end
    w = data; n = 0;
    while (!tgt(d, w)) begin
      w = d ? (w >> 1) : (w << 1);
      n++;
    end
    e = '{data: w, cnt: CNT_W'(n), zero: 1'b0};
`ifdef FAST_SHIFT_EN
    w = data; steps = 0;
    while (!tgt(d, w)) begin
      if ((d && w[3:0] == 4'd0) || (!d && w[WIDTH-1:WIDTH-4] == 4'd0))
        w = d ? (w >> 4) : (w << 4);
      else
        w = d ? (w >> 1) : (w << 1);
      steps++;
    end
    lat = steps + 1;
`else
    steps = n;
    lat = steps + 1;
`endif
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        $display("txn out_data=%h sh_cnt=%0d zero=%0b (exp %h %0d %0b)",
                 out_data, sh_cnt, zero, e.data, e.cnt, e.zero);
        check("out_data", 64'(out_data), 64'(e.data));
        check("sh_cnt", 64'(sh_cnt), 64'(e.cnt));
        check("zero", 64'(zero), 64'(e.zero));
      end
    end
  end

  task automatic run_op(input logic d, input logic [WIDTH-1:0] data, input bit spam);
    exp_t e;
    int lat, k;
    bit seen;
    model(d, data, e, lat);
    sb_q.push_back(e);
    @(negedge clk);
    check("idle_before_start", 64'(busy), 64'd0);
    start = 1'b1; dir = d; in_data = data;
    @(posedge clk);
    #1;
    start = 1'b0; dir = ~d; in_data = $urandom;
    k = 0; seen = 0;
    while (!seen && k < 200) begin
      @(posedge clk);
      k++;
      #1;
      if (done) begin
        seen = 1;
        start = 1'b0;
      end else if (spam) begin
        check("busy_hold", 64'(busy), 64'd1);
        start = k[0];
        in_data = $urandom;
        dir = $urandom_range(0, 1);
      end
    end
    start = 1'b0;
    check("latency", 64'(k), 64'(lat));
    @(posedge clk);
    #1;
    check("done_single_pulse", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    bit saw_done;
    logic [WIDTH-1:0] rnd;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_sh_cnt", 64'(sh_cnt), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 32'h0000_0100, 1'b0);
    run_op(1'b0, 32'h8000_0001, 1'b0);
    run_op(1'b1, 32'h0001_0000, 1'b0);

    // Results must hold while idle.
    repeat (3) @(posedge clk);
    #1;
    check("hold_out_data", 64'(out_data), 64'h0000_0001);
    check("hold_sh_cnt", 64'(sh_cnt), 64'd16);

    run_op(1'b0, 32'h0000_0000, 1'b0);
    run_op(1'b0, 32'h0000_0001, 1'b0);
    run_op(1'b1, 32'h0000_0000, 1'b0);
    run_op(1'b0, 32'h0000_0100, 1'b1);
    run_op(1'b1, 32'h8000_0000, 1'b1);
    run_op(1'b1, 32'h0000_0001, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rnd = $urandom;
      rnd = rnd >> $urandom_range(0, 31);
      if (rnd == '0) rnd = 32'h0000_0040;
      run_op(1'(i % 2), rnd, 1'b0);
    end

    // Abort a 23-shift operation with reset at edge E+5.
    @(negedge clk);
    start = 1'b1; dir = 1'b0; in_data = 32'h0000_0100;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    check("abort_sh_cnt", 64'(sh_cnt), 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);

    run_op(1'b0, 32'h0000_0001, 1'b0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
